// File: rtl/bank_cmd_stats_counter.sv
// bank_cmd_stats_counter
//   Decodes DRAM command strobes on the command bus and keeps saturating
//   per-bank, per-command-type counters, per-bank open/closed state, a rank
//   self-refresh tracker and a free-running cycle counter. Counters are read
//   through a registered, fully pipelined read port.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cmd_fire          a command is issued this cycle
//   cmd_bank          target bank of the command
//   cs, ras, cas, we  command strobes (cs active low; cs=1 is a NOP)
//   clear_all         zero all counters and cycle_count on the next edge
//   rd_en             counter read request
//   rd_bank, rd_type  counter to read (type: REF PRE ACT RD WR SRE SRX VIOL)
//   rd_valid, rd_data read response, one cycle after rd_en
//   cycle_count       cycles since reset or last clear_all
//   in_self_refresh   rank is in self refresh
module bank_cmd_stats_counter #(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 32,
  parameter int CYC_W     = 64,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_fire,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic              cs,
  input  logic              ras,
  input  logic              cas,
  input  logic              we,
  input  logic              clear_all,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [2:0]        rd_type,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              in_self_refresh
);

  typedef enum logic [2:0] {
    CT_REF  = 3'd0,
    CT_PRE  = 3'd1,
    CT_ACT  = 3'd2,
    CT_RD   = 3'd3,
    CT_WR   = 3'd4,
    CT_SRE  = 3'd5,
    CT_SRX  = 3'd6,
    CT_VIOL = 3'd7
  } cnt_type_e;

  typedef enum logic {
    ACTIVE,
    SELF_REFRESH
  } sr_state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  logic [CNT_W-1:0]     cnt_q [NUM_BANKS][8];
  logic [NUM_BANKS-1:0] open_q, open_d;
  sr_state_e            state_q, state_d;

  logic      cmd_bank_ok, rd_bank_ok;
  logic      cmd_valid;
  logic      type_inc;
  logic      viol;
  logic      bank_open;
  cnt_type_e cmd_type;

  // Bank indices can only exceed the bank count when NUM_BANKS is not a
  // power of two; out-of-range commands are ignored and reads return 0.
  if (NUM_BANKS == (1 << BANK_W)) begin : g_full_range
    assign cmd_bank_ok = 1'b1;
    assign rd_bank_ok  = 1'b1;
  end else begin : g_partial_range
    assign cmd_bank_ok = (32'(cmd_bank) < NUM_BANKS);
    assign rd_bank_ok  = (32'(rd_bank) < NUM_BANKS);
  end

  assign cmd_valid       = cmd_fire & ~cs & cmd_bank_ok;
  assign in_self_refresh = (state_q == SELF_REFRESH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Decode, bank-state and self-refresh next-state logic.
  always_comb begin
    state_d   = state_q;
    open_d    = open_q;
    cmd_type  = CT_REF;
    type_inc  = 1'b0;
    viol      = 1'b0;
    bank_open = open_q[cmd_bank];
    if (cmd_valid) begin
      type_inc = 1'b1;
      case ({ras, cas, we})
        3'b001:  cmd_type = CT_REF;
        3'b010:  cmd_type = CT_PRE;
        3'b011:  cmd_type = CT_ACT;
        3'b101:  cmd_type = CT_RD;
        3'b100:  cmd_type = CT_WR;
        3'b000:  cmd_type = CT_SRE;
        3'b111:  cmd_type = CT_SRX;
        default: type_inc = 1'b0;  // 110: unmapped, counts as VIOL only
      endcase
      if (state_q == SELF_REFRESH) begin
        // Only SRX is legal in self refresh; anything else is counted but
        // leaves bank state alone.
        if (type_inc && cmd_type == CT_SRX) begin
          state_d = ACTIVE;
        end else begin
          viol = 1'b1;
        end
      end else if (!type_inc) begin
        viol = 1'b1;
      end else begin
        case (cmd_type)
          CT_REF: viol = |open_q;
          CT_PRE: open_d[cmd_bank] = 1'b0;
          CT_ACT: begin
            if (bank_open) viol = 1'b1;
            else           open_d[cmd_bank] = 1'b1;
          end
          CT_RD, CT_WR: viol = ~bank_open;
          CT_SRE: begin
            viol    = |open_q;
            open_d  = '0;
            state_d = SELF_REFRESH;
          end
          default: viol = 1'b1;  // SRX while active
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACTIVE;
      open_q  <= '0;
    end else begin
      state_q <= state_d;
      open_q  <= open_d;
    end
  end

  // A violating command bumps both its type counter and VIOL; type is never
  // VIOL, so no counter sees two increments in one cycle.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned t = 0; t < 8; t++) begin
        if (reset || clear_all) begin
          cnt_q[b][t] <= '0;
        end else if (cmd_valid && BANK_W'(b) == cmd_bank) begin
          if (type_inc && 3'(t) == cmd_type) cnt_q[b][t] <= sat_inc(cnt_q[b][t]);
          if (viol && 3'(t) == CT_VIOL)      cnt_q[b][t] <= sat_inc(cnt_q[b][t]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + CYC_ONE;
    end
  end

  // Reads sample the array before this edge's update, so same-cycle
  // increments and clears are not visible in the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_bank_ok ? cnt_q[rd_bank][rd_type] : '0;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_stats_counter.sv
// tb_bank_cmd_stats_counter
//   Directed bench for bank_cmd_stats_counter (8 banks, 4-bit counters,
//   16-bit cycle counter). Read requests push their expected value and due
//   cycle into a scoreboard; a monitor on the falling edge pops and checks
//   each rd_valid response. Status outputs are checked directly.
module tb_bank_cmd_stats_counter;

  localparam int NB = 8;
  localparam int CW = 4;
  localparam int YW = 16;

  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_SRE = 4'b0000;
  localparam logic [3:0] C_SRX = 4'b0111;
  localparam logic [3:0] C_BAD = 4'b0110;
  localparam logic [3:0] C_NOP = 4'b1111;

  localparam int T_REF = 0, T_PRE = 1, T_ACT = 2, T_RD = 3;
  localparam int T_WR = 4, T_SRE = 5, T_SRX = 6, T_VIOL = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_fire;
  logic [2:0]    cmd_bank;
  logic          cs, ras, cas, we;
  logic          clear_all;
  logic          rd_en;
  logic [2:0]    rd_bank;
  logic [2:0]    rd_type;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [YW-1:0] cycle_count;
  logic          in_self_refresh;

  bank_cmd_stats_counter #(
    .NUM_BANKS(NB),
    .CNT_W    (CW),
    .CYC_W    (YW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_fire       (cmd_fire),
    .cmd_bank       (cmd_bank),
    .cs             (cs),
    .ras            (ras),
    .cas            (cas),
    .we             (we),
    .clear_all      (clear_all),
    .rd_en          (rd_en),
    .rd_bank        (rd_bank),
    .rd_type        (rd_type),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .cycle_count    (cycle_count),
    .in_self_refresh(in_self_refresh)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] data;
    int unsigned   due;
    string         name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [CW-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: responses must arrive in order, exactly one cycle
  // after their request; rd_data must hold while rd_valid is low.
  always @(negedge clk) begin
    if (reset) begin
      last_data = '0;
    end else if (rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_rd_valid: rd_data=%0d at cycle %0d, no read outstanding", rd_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (rd_data !== mon_e.data || cyc != mon_e.due) begin
          errors++;
          $display("FAIL %s: rd_data=%0d at cycle %0d, expected %0d at cycle %0d",
                   mon_e.name, rd_data, cyc, mon_e.data, mon_e.due);
        end
      end
      last_data = rd_data;
    end else begin
      checks++;
      if (rd_data !== last_data) begin
        errors++;
        $display("FAIL rd_data_hold: rd_data=%0d, expected held %0d", rd_data, last_data);
      end
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: no rd_valid at cycle %0d, expected %0d", mon_e.name, cyc, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_fire  = 1'b0;
    {cs, ras, cas, we} = C_NOP;
    clear_all = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic step(input logic fire, input int bank, input logic [3:0] code,
                      input logic clr, input logic ren, input int rbank,
                      input int rtype, input int exp, input string nm);
    cmd_fire  = fire;
    cmd_bank  = 3'(bank);
    {cs, ras, cas, we} = code;
    clear_all = clr;
    rd_en     = ren;
    rd_bank   = 3'(rbank);
    rd_type   = 3'(rtype);
    if (ren) sb.push_back('{CW'(exp), cyc + 1, nm});
    tick();
    idle();
  endtask

  task automatic cmd(input int bank, input logic [3:0] code);
    step(1'b1, bank, code, 1'b0, 1'b0, 0, 0, 0, "");
  endtask

  task automatic rd(input int bank, input int typ, input int exp, input string nm);
    step(1'b0, 0, C_NOP, 1'b0, 1'b1, bank, typ, exp, nm);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    tick();  // let the last outstanding read response land
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle();
    reset    = 1'b1;
    cmd_bank = '0;
    rd_bank  = '0;
    rd_type  = '0;
    tick();
    // Reset must override a command and a read in the same cycle.
    cmd_fire = 1'b1; cmd_bank = 3'd2; {cs, ras, cas, we} = C_ACT; rd_en = 1'b1;
    tick();
    idle();
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_cycle_count", cycle_count, 0);
    chk("reset_in_sr", in_self_refresh, 0);
    reset = 1'b0;
    tick();
    chk("cycle_count_first", cycle_count, 1);

    // Basic open / read / close sequence on bank 2.
    cmd(2, C_ACT);
    repeat (3) cmd(2, C_RD);
    cmd(2, C_PRE);
    rd(2, T_ACT, 1, "t1_b2_act");
    rd(2, T_RD, 3, "t1_b2_rd");
    rd(2, T_PRE, 1, "t1_b2_pre");
    rd(2, T_VIOL, 0, "t1_b2_viol");

    // RD to a closed bank and double ACT; the trailing RD finds it open.
    cmd(5, C_RD);
    cmd(5, C_ACT);
    cmd(5, C_ACT);
    cmd(5, C_RD);
    rd(5, T_RD, 2, "t2_b5_rd");
    rd(5, T_ACT, 2, "t2_b5_act");
    rd(5, T_VIOL, 2, "t2_b5_viol");

    // Self-refresh entry with an open bank, commands inside, exit.
    do_reset();
    cmd(1, C_ACT);
    chk("t3_sr_before", in_self_refresh, 0);
    cmd(1, C_SRE);
    chk("t3_sr_entered", in_self_refresh, 1);
    cmd(3, C_ACT);
    chk("t3_sr_held", in_self_refresh, 1);
    cmd(3, C_SRX);
    chk("t3_sr_exited", in_self_refresh, 0);
    cmd(3, C_RD);
    cmd(1, C_RD);
    cmd(0, C_SRX);
    chk("t3_sr_stays_active", in_self_refresh, 0);
    rd(1, T_ACT, 1, "t3_b1_act");
    rd(1, T_SRE, 1, "t3_b1_sre");
    rd(1, T_RD, 1, "t3_b1_rd");
    rd(1, T_VIOL, 2, "t3_b1_viol");
    rd(3, T_ACT, 1, "t3_b3_act");
    rd(3, T_SRX, 1, "t3_b3_srx");
    rd(3, T_RD, 1, "t3_b3_rd");
    rd(3, T_VIOL, 2, "t3_b3_viol");
    rd(0, T_SRX, 1, "t3_b0_srx");
    rd(0, T_VIOL, 1, "t3_b0_viol");

    // Saturation at 2^CNT_W-1.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cmd(4, C_ACT);
      cmd(4, C_PRE);
    end
    rd(4, T_ACT, 14, "t4_b4_act_pre_sat");
    rd(4, T_PRE, 14, "t4_b4_pre_pre_sat");
    for (int i = 0; i < 3; i++) begin
      cmd(4, C_ACT);
      cmd(4, C_PRE);
    end
    rd(4, T_ACT, 15, "t4_b4_act_sat");
    rd(4, T_PRE, 15, "t4_b4_pre_sat");
    rd(4, T_VIOL, 0, "t4_b4_viol");

    // clear_all with a same-cycle ACT and read.
    do_reset();
    cmd(0, C_ACT); cmd(0, C_RD); cmd(0, C_WR); cmd(0, C_PRE);
    cmd(6, C_ACT); cmd(6, C_PRE); cmd(2, C_REF);
    cmd(7, C_ACT); cmd(7, C_PRE); cmd(3, C_REF);
    step(1'b1, 6, C_ACT, 1'b1, 1'b1, 6, T_ACT, 1, "t5_read_in_clear_cycle");
    chk("t5_cycle_after_clear", cycle_count, 0);
    rd(6, T_ACT, 0, "t5_b6_act_cleared");
    chk("t5_cycle_plus1", cycle_count, 1);
    rd(0, T_RD, 0, "t5_b0_rd_cleared");
    rd(7, T_ACT, 0, "t5_b7_act_cleared");
    cmd(6, C_RD);
    chk("t5_cycle_plus4", cycle_count, 4);
    rd(6, T_VIOL, 0, "t5_b6_viol_open");
    rd(6, T_RD, 1, "t5_b6_rd");

    // NOPs with arbitrary strobes, then one unmapped encoding on bank 7.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cmd(i % NB, {1'b1, 3'(i)});
    end
    chk("t6_nop_no_sr", in_self_refresh, 0);
    cmd(7, C_BAD);
    for (int b = 0; b < NB; b++) begin
      for (int t = 0; t < 8; t++) begin
        rd(b, t, (b == 7 && t == T_VIOL) ? 1 : 0, $sformatf("t6_b%0d_t%0d", b, t));
      end
    end

    for (int i = 0; i < 5 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_cmd_stats_counter.md
Name: bank_cmd_stats_counter

Overview:
- Synthesizable, multi-bank successor to the per-bank simulation CSV logger.
- Decodes DRAM command strobes (cs/ras/cas/we) on every fired command and keeps saturating per-bank, per-command-type counters.
- Tracks per-bank open/closed state and rank self-refresh state, and counts protocol violations.
- Sits beside the bank schedulers on the command bus; firmware or the testbench reads counters through a registered read port.

Parameters:
- NUM_BANKS, 8, number of banks tracked; must be ≥2. BANK_W = $clog2(NUM_BANKS).
- CNT_W, 32, width of each counter; counters saturate at all-ones.
- CYC_W, 64, width of the free-running cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_fire  in  1  command issued this cycle
- cmd_bank  in  BANK_W  target bank of the command
- cs  in  1  chip select, active low
- ras  in  1  row strobe
- cas  in  1  column strobe
- we  in  1  write enable
- clear_all  in  1  zero all counters and the cycle counter
- rd_en  in  1  counter read request
- rd_bank  in  BANK_W  bank to read
- rd_type  in  3  counter index: 0 REF, 1 PRE, 2 ACT, 3 RD, 4 WR, 5 SRE, 6 SRX, 7 VIOL
- rd_valid  out  1  rd_data valid
- rd_data  out  CNT_W  counter value
- cycle_count  out  CYC_W  cycles since reset or last clear_all
- in_self_refresh  out  1  rank currently in self refresh

Behaviour:
- Reset: all counters 0, all banks closed, in_self_refresh=0, rd_valid=0, rd_data=0, cycle_count=0. Reset overrides every other input.
- Decode {cs,ras,cas,we}, applied only when cmd_fire=1:
  - 0001 REF, 0010 PRE, 0011 ACT, 0101 RD, 0100 WR, 0000 SRE, 0111 SRX.
  - 0110 is unmapped: counts VIOL only.
  - cs=1 is a NOP: nothing is counted and no state changes.
- Counting: each decoded command increments counter[cmd_bank][type] by 1, saturating at 2^CNT_W-1. A violating command increments both its type counter and counter[cmd_bank][VIOL]; VIOL increments by 1 per command.
- Bank state (open[] bits):
  - ACT on an open bank: VIOL; bank stays open.
  - ACT on a closed bank: opens it.
  - PRE closes the bank. PRE on a closed bank is legal.
  - RD/WR on a closed bank: VIOL; state unchanged.
  - REF with any bank open: VIOL.
- Self-refresh FSM, states ACTIVE and SELF_REFRESH:
  - ACTIVE --SRE--> SELF_REFRESH. SRE with any bank open is a VIOL but the transition still happens, and all banks are forced closed.
  - SELF_REFRESH --SRX--> ACTIVE.
  - SRX in ACTIVE: VIOL, stay in ACTIVE.
  - Any non-SRX command in SELF_REFRESH: VIOL; the command is counted under its type, causes no bank-state change, and the FSM stays in SELF_REFRESH.
  - in_self_refresh = (state == SELF_REFRESH), registered.
- cycle_count increments every cycle out of reset; it wraps at 2^CYC_W.
- clear_all:
  - Zeroes all counters and cycle_count on the next edge.
  - A command in the same cycle is not counted but still updates bank and FSM state.
  - Does not alter open[] or the FSM.
- Read port:
  - Latency 1: rd_en at cycle N gives rd_valid=1 and rd_data at N+1. rd_valid=0 otherwise; rd_data holds its last value.
  - Read and update of the same counter in one cycle returns the pre-update value.
  - Read in the same cycle as clear_all returns the pre-clear value.
  - rd_en is accepted every cycle (fully pipelined).
  - rd_bank ≥ NUM_BANKS returns 0 with rd_valid=1.
- Storage: flop array of NUM_BANKS×8×CNT_W bits, with at most one increment per cycle.

Test Plan:
- Reset, then ACT b2 (0011), RD b2 (0101) ×3, PRE b2 (0010); read types 2/3/1/7 of b2 -> 1/3/1/0, each rd_valid one cycle after rd_en.
- RD b5 while closed, then ACT b5 twice -> b5 RD=1, ACT=2, VIOL=2; open[5]=1.
- ACT b1, then SRE b1 -> in_self_refresh=1 on the next cycle, VIOL b1=1. Then ACT b3 -> VIOL b3=1 and b3 stays closed. Then SRX b3 -> in_self_refresh=0. Then SRX b0 -> VIOL b0=1.
- Force b4 ACT counter to 2^CNT_W-2 (CNT_W=4 build: 14), issue 3 ACT/PRE pairs -> reads 15, no wrap.
- Issue 10 commands, assert clear_all together with an ACT b6 -> all counters read 0 and cycle_count restarts at 0, but open[6]=1 (a following RD b6 adds no VIOL). Read b6 ACT issued in the clear cycle -> returns the pre-clear value.
- cs=1 with arbitrary ras/cas/we for 20 cycles, plus encoding 0110 once on b7 -> only b7 VIOL=1, all else 0.
